// File: rtl/mouse_master_sm_gen.sv
// PS/2 mouse host state machine: runs the device init sequence (reset,
// optional IntelliMouse wheel detect, sample rate, enable streaming) with
// bounded retries and timeouts, then decodes 3- or 4-byte stream packets.
module mouse_master_sm_gen #(
  parameter bit         WHEEL_EN       = 1'b1,
  parameter logic [7:0] SAMPLE_RATE    = 8'd100,
  parameter int         INIT_TIMEOUT   = 50_000_000,
  parameter int         PACKET_TIMEOUT = 1_000_000,
  parameter int         MAX_RETRIES    = 3
) (
  input  logic       CLK,
  input  logic       RESET_N,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY,
  output logic [7:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_DX,
  output logic [7:0] MOUSE_DY,
  output logic [7:0] MOUSE_DZ,
  output logic       SEND_INTERRUPT,
  output logic       WHEEL_MODE,
  output logic       INIT_DONE,
  output logic       INIT_FAIL
);

  // Command table length and the positions the sequencer branches on
  localparam int          NCMD     = WHEEL_EN ? 11 : 4;
  localparam logic [3:0]  LAST_IDX = 4'(NCMD - 1);
  localparam logic [3:0]  ID_IDX   = 4'd7;
  localparam logic [31:0] INIT_LIM = 32'(INIT_TIMEOUT - 1);
  localparam logic [31:0] PKT_LIM  = 32'(PACKET_TIMEOUT - 1);
  localparam logic [7:0]  RETRY_LIM = 8'(MAX_RETRIES);

  typedef enum logic [3:0] {
    S_SEND_CMD,
    S_WAIT_SENT,
    S_WAIT_ACK,
    S_WAIT_AA,
    S_WAIT_ID0,
    S_WAIT_ID,
    S_STREAM_B0,
    S_STREAM_B1,
    S_STREAM_B2,
    S_STREAM_B3,
    S_FAIL
  } state_t;

  state_t      state;
  logic [3:0]  idx;
  logic [7:0]  retries;
  logic [31:0] timer;
  logic [7:0]  sh_status;
  logic [7:0]  sh_dx;
  logic [7:0]  sh_dy;
  logic        rx_ok;
  logic        rx_err;
  logic        init_to;
  logic        pkt_to;
  logic        fail_evt;

  // Init command sequence; the F3 C8 / F3 64 / F3 50 knock precedes the F2 ID read
  function automatic logic [7:0] cmd_byte(input logic [3:0] i);
    logic [7:0] b;
    b = 8'hF4;
    if (WHEEL_EN) begin
      case (i)
        4'd0:    b = 8'hFF;
        4'd1:    b = 8'hF3;
        4'd2:    b = 8'hC8;
        4'd3:    b = 8'hF3;
        4'd4:    b = 8'h64;
        4'd5:    b = 8'hF3;
        4'd6:    b = 8'h50;
        4'd7:    b = 8'hF2;
        4'd8:    b = 8'hF3;
        4'd9:    b = SAMPLE_RATE;
        default: b = 8'hF4;
      endcase
    end else begin
      case (i)
        4'd0:    b = 8'hFF;
        4'd1:    b = 8'hF3;
        4'd2:    b = SAMPLE_RATE;
        default: b = 8'hF4;
      endcase
    end
    return b;
  endfunction

  assign rx_ok   = BYTE_READY && (BYTE_ERROR_CODE == 2'b00);
  assign rx_err  = BYTE_READY && (BYTE_ERROR_CODE != 2'b00);
  assign init_to = (timer >= INIT_LIM);
  assign pkt_to  = (timer >= PKT_LIM);

  // Detect any init failure: wrong reply, receive error or waiting too long
  always_comb begin
    fail_evt = 1'b0;
    case (state)
      S_WAIT_SENT: fail_evt = !BYTE_SENT && init_to;
      S_WAIT_ACK:  fail_evt = BYTE_READY ? (rx_err || BYTE_READ != 8'hFA) : init_to;
      S_WAIT_AA:   fail_evt = BYTE_READY ? (rx_err || BYTE_READ != 8'hAA) : init_to;
      S_WAIT_ID0:  fail_evt = BYTE_READY ? (rx_err || BYTE_READ != 8'h00) : init_to;
      S_WAIT_ID:   fail_evt = BYTE_READY ? rx_err : init_to;
      default:     fail_evt = 1'b0;
    endcase
  end

  // Main sequencer: init handshake, retry/fail handling and packet assembly
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state          <= S_SEND_CMD;
      idx            <= 4'd0;
      retries        <= 8'd0;
      timer          <= 32'd0;
      SEND_BYTE      <= 1'b0;
      BYTE_TO_SEND   <= 8'h00;
      READ_ENABLE    <= 1'b0;
      MOUSE_STATUS   <= 8'h00;
      MOUSE_DX       <= 8'h00;
      MOUSE_DY       <= 8'h00;
      MOUSE_DZ       <= 8'h00;
      SEND_INTERRUPT <= 1'b0;
      WHEEL_MODE     <= 1'b0;
      INIT_DONE      <= 1'b0;
      INIT_FAIL      <= 1'b0;
      sh_status      <= 8'h00;
      sh_dx          <= 8'h00;
      sh_dy          <= 8'h00;
    end else begin
      SEND_BYTE      <= 1'b0;
      SEND_INTERRUPT <= 1'b0;
      timer          <= timer + 32'd1;
      case (state)
        S_SEND_CMD: begin
          BYTE_TO_SEND <= cmd_byte(idx);
          SEND_BYTE    <= 1'b1;
          READ_ENABLE  <= 1'b0;
          timer        <= 32'd0;
          state        <= S_WAIT_SENT;
        end
        S_WAIT_SENT: begin
          if (BYTE_SENT) begin
            READ_ENABLE <= 1'b1;
            timer       <= 32'd0;
            state       <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (rx_ok && BYTE_READ == 8'hFA) begin
            timer <= 32'd0;
            if (idx == 4'd0) begin
              state <= S_WAIT_AA;
            end else if (WHEEL_EN && idx == ID_IDX) begin
              state <= S_WAIT_ID;
            end else if (idx == LAST_IDX) begin
              INIT_DONE <= 1'b1;
              state     <= S_STREAM_B0;
            end else begin
              idx         <= idx + 4'd1;
              READ_ENABLE <= 1'b0;
              state       <= S_SEND_CMD;
            end
          end
        end
        S_WAIT_AA: begin
          if (rx_ok && BYTE_READ == 8'hAA) begin
            timer <= 32'd0;
            state <= S_WAIT_ID0;
          end
        end
        S_WAIT_ID0: begin
          if (rx_ok && BYTE_READ == 8'h00) begin
            idx         <= idx + 4'd1;
            READ_ENABLE <= 1'b0;
            timer       <= 32'd0;
            state       <= S_SEND_CMD;
          end
        end
        S_WAIT_ID: begin
          if (rx_ok) begin
            WHEEL_MODE  <= (BYTE_READ == 8'h03);
            idx         <= idx + 4'd1;
            READ_ENABLE <= 1'b0;
            timer       <= 32'd0;
            state       <= S_SEND_CMD;
          end
        end
        S_STREAM_B0: begin
          // No inter-byte timeout while idle; bit3 marks a valid first byte
          timer <= 32'd0;
          if (rx_ok && BYTE_READ[3]) begin
            sh_status <= BYTE_READ;
            state     <= S_STREAM_B1;
          end
        end
        S_STREAM_B1: begin
          if (BYTE_READY) begin
            timer <= 32'd0;
            if (rx_err) begin
              state <= S_STREAM_B0;
            end else begin
              sh_dx <= BYTE_READ;
              state <= S_STREAM_B2;
            end
          end else if (pkt_to) begin
            timer <= 32'd0;
            state <= S_STREAM_B0;
          end
        end
        S_STREAM_B2: begin
          if (BYTE_READY) begin
            timer <= 32'd0;
            if (rx_err) begin
              state <= S_STREAM_B0;
            end else if (WHEEL_MODE) begin
              sh_dy <= BYTE_READ;
              state <= S_STREAM_B3;
            end else begin
              MOUSE_STATUS   <= sh_status;
              MOUSE_DX       <= sh_dx;
              MOUSE_DY       <= BYTE_READ;
              MOUSE_DZ       <= 8'h00;
              SEND_INTERRUPT <= 1'b1;
              state          <= S_STREAM_B0;
            end
          end else if (pkt_to) begin
            timer <= 32'd0;
            state <= S_STREAM_B0;
          end
        end
        S_STREAM_B3: begin
          if (BYTE_READY) begin
            timer <= 32'd0;
            if (!rx_err) begin
              MOUSE_STATUS   <= sh_status;
              MOUSE_DX       <= sh_dx;
              MOUSE_DY       <= sh_dy;
              MOUSE_DZ       <= BYTE_READ;
              SEND_INTERRUPT <= 1'b1;
            end
            state <= S_STREAM_B0;
          end else if (pkt_to) begin
            timer <= 32'd0;
            state <= S_STREAM_B0;
          end
        end
        S_FAIL: begin
          timer       <= timer;
          READ_ENABLE <= 1'b0;
          INIT_FAIL   <= 1'b1;
        end
        default: state <= S_FAIL;
      endcase

      // A failed init step either restarts the whole sequence or gives up
      if (fail_evt) begin
        timer       <= 32'd0;
        READ_ENABLE <= 1'b0;
        if (retries < RETRY_LIM) begin
          retries    <= retries + 8'd1;
          WHEEL_MODE <= 1'b0;
          idx        <= 4'd0;
          state      <= S_SEND_CMD;
        end else begin
          INIT_FAIL <= 1'b1;
          state     <= S_FAIL;
        end
      end
    end
  end

endmodule

// File: tb/tb_mouse_master_sm_gen.sv
// Bench for mouse_master_sm_gen: a wheel-capable instance (index 0) and a
// 3-byte-only instance (index 1), each driven by a small PS/2 device model.
module tb_mouse_master_sm_gen;

  logic       clk;
  logic       rst_n        [2];
  logic       send_byte    [2];
  logic [7:0] byte_to_send [2];
  logic       byte_sent    [2];
  logic       read_enable  [2];
  logic [7:0] byte_read    [2];
  logic [1:0] err_code     [2];
  logic       byte_ready   [2];
  logic [7:0] m_status     [2];
  logic [7:0] m_dx         [2];
  logic [7:0] m_dy         [2];
  logic [7:0] m_dz         [2];
  logic       send_int     [2];
  logic       wheel_mode   [2];
  logic       init_done    [2];
  logic       init_fail    [2];

  int checks = 0;
  int errors = 0;
  int int_cnt0 = 0;
  int int_cnt1 = 0;
  int base;
  int n;
  logic ok;
  logic [7:0] e8;

  logic [7:0]  cmd_q [$];
  logic [31:0] pkt_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mouse_master_sm_gen #(
    .WHEEL_EN(1'b1), .SAMPLE_RATE(8'd100), .INIT_TIMEOUT(100),
    .PACKET_TIMEOUT(40), .MAX_RETRIES(1)
  ) dut_w (
    .CLK(clk), .RESET_N(rst_n[0]), .SEND_BYTE(send_byte[0]),
    .BYTE_TO_SEND(byte_to_send[0]), .BYTE_SENT(byte_sent[0]),
    .READ_ENABLE(read_enable[0]), .BYTE_READ(byte_read[0]),
    .BYTE_ERROR_CODE(err_code[0]), .BYTE_READY(byte_ready[0]),
    .MOUSE_STATUS(m_status[0]), .MOUSE_DX(m_dx[0]), .MOUSE_DY(m_dy[0]),
    .MOUSE_DZ(m_dz[0]), .SEND_INTERRUPT(send_int[0]),
    .WHEEL_MODE(wheel_mode[0]), .INIT_DONE(init_done[0]),
    .INIT_FAIL(init_fail[0])
  );

  mouse_master_sm_gen #(
    .WHEEL_EN(1'b0), .SAMPLE_RATE(8'd100), .INIT_TIMEOUT(100),
    .PACKET_TIMEOUT(40), .MAX_RETRIES(3)
  ) dut_n (
    .CLK(clk), .RESET_N(rst_n[1]), .SEND_BYTE(send_byte[1]),
    .BYTE_TO_SEND(byte_to_send[1]), .BYTE_SENT(byte_sent[1]),
    .READ_ENABLE(read_enable[1]), .BYTE_READ(byte_read[1]),
    .BYTE_ERROR_CODE(err_code[1]), .BYTE_READY(byte_ready[1]),
    .MOUSE_STATUS(m_status[1]), .MOUSE_DX(m_dx[1]), .MOUSE_DY(m_dy[1]),
    .MOUSE_DZ(m_dz[1]), .SEND_INTERRUPT(send_int[1]),
    .WHEEL_MODE(wheel_mode[1]), .INIT_DONE(init_done[1]),
    .INIT_FAIL(init_fail[1])
  );

  // Count interrupt pulses so duplicate or missing publishes are visible
  always @(posedge clk) begin
    if (send_int[0]) int_cnt0 <= int_cnt0 + 1;
    if (send_int[1]) int_cnt1 <= int_cnt1 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One-cycle receive pulse; called at a negedge, returns at the next one
  task automatic give_byte(input int d, input logic [7:0] b, input logic [1:0] e);
    byte_read[d]  = b;
    err_code[d]   = e;
    byte_ready[d] = 1'b1;
    @(negedge clk);
    byte_ready[d] = 1'b0;
    err_code[d]   = 2'b00;
  endtask

  task automatic pulse_sent(input int d);
    byte_sent[d] = 1'b1;
    @(negedge clk);
    byte_sent[d] = 1'b0;
  endtask

  task automatic wait_send(input int d, output logic found);
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (send_byte[d]) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("send_seen", {31'd0, found}, 32'd1);
  endtask

  // Device model: accept one command, check it against the queue, reply
  task automatic device_cmd(input int d, input logic [7:0] id_reply, input bit reject);
    logic       got;
    logic [7:0] exp;
    wait_send(d, got);
    if (!got) return;
    exp = (cmd_q.size() > 0) ? cmd_q.pop_front() : 8'hXX;
    chk("cmd_byte", byte_to_send[d], exp);
    @(negedge clk);
    chk("send_one_cycle", send_byte[d], 0);
    chk("cmd_hold", byte_to_send[d], exp);
    chk("rden_during_tx", read_enable[d], 0);
    pulse_sent(d);
    chk("rden_wait_ack", read_enable[d], 1);
    if (reject) begin
      give_byte(d, 8'hFE, 2'b00);
      return;
    end
    give_byte(d, 8'hFA, 2'b00);
    if (exp == 8'hFF) begin
      give_byte(d, 8'hAA, 2'b00);
      give_byte(d, 8'h00, 2'b00);
    end else if (exp == 8'hF2) begin
      give_byte(d, id_reply, 2'b00);
    end
  endtask

  task automatic push_wheel_cmds();
    cmd_q.push_back(8'hFF); cmd_q.push_back(8'hF3); cmd_q.push_back(8'hC8);
    cmd_q.push_back(8'hF3); cmd_q.push_back(8'h64); cmd_q.push_back(8'hF3);
    cmd_q.push_back(8'h50); cmd_q.push_back(8'hF2); cmd_q.push_back(8'hF3);
    cmd_q.push_back(8'h64); cmd_q.push_back(8'hF4);
  endtask

  // Called at the negedge right after the final packet byte was taken
  task automatic check_pkt(input int d);
    logic [31:0] e;
    e = (pkt_q.size() > 0) ? pkt_q.pop_front() : 32'hDEADBEEF;
    chk("int_pulse", send_int[d], 1);
    chk("pkt_status", m_status[d], e[31:24]);
    chk("pkt_dx", m_dx[d], e[23:16]);
    chk("pkt_dy", m_dy[d], e[15:8]);
    chk("pkt_dz", m_dz[d], e[7:0]);
  endtask

  task automatic check_hold0(input logic [31:0] e, input int b);
    chk("hold_status", m_status[0], e[31:24]);
    chk("hold_dx", m_dx[0], e[23:16]);
    chk("hold_dy", m_dy[0], e[15:8]);
    chk("hold_dz", m_dz[0], e[7:0]);
    chk("hold_no_int", int_cnt0 - b, 0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d]      = 1'b0;
      byte_sent[d]  = 1'b0;
      byte_read[d]  = 8'h00;
      err_code[d]   = 2'b00;
      byte_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("rst_send", send_byte[0], 0);
    chk("rst_tx_byte", byte_to_send[0], 0);
    chk("rst_rden", read_enable[0], 0);
    chk("rst_status", m_status[0], 0);
    chk("rst_done", init_done[0], 0);
    chk("rst_fail", init_fail[0], 0);

    // 3-byte-only device: FF, F3, 64, F4
    rst_n[1] = 1'b1;
    cmd_q.push_back(8'hFF); cmd_q.push_back(8'hF3);
    cmd_q.push_back(8'h64); cmd_q.push_back(8'hF4);
    repeat (4) device_cmd(1, 8'h00, 1'b0);
    chk("nw_init_done", init_done[1], 1);
    chk("nw_wheel", wheel_mode[1], 0);
    base = int_cnt1;
    pkt_q.push_back(32'h09102000);
    give_byte(1, 8'h09, 2'b00);
    give_byte(1, 8'h10, 2'b00);
    give_byte(1, 8'h20, 2'b00);
    check_pkt(1);
    @(negedge clk);
    chk("nw_int_low", send_int[1], 0);
    chk("nw_int_once", int_cnt1 - base, 1);

    // Wheel device: FF rejected once, then a full init with ID 03
    rst_n[0] = 1'b1;
    cmd_q.push_back(8'hFF);
    device_cmd(0, 8'h00, 1'b1);
    push_wheel_cmds();
    repeat (11) device_cmd(0, 8'h03, 1'b0);
    chk("w_init_done", init_done[0], 1);
    chk("w_wheel", wheel_mode[0], 1);
    chk("w_no_fail", init_fail[0], 0);

    // 4-byte packet
    base = int_cnt0;
    pkt_q.push_back(32'h0805FB01);
    give_byte(0, 8'h08, 2'b00);
    give_byte(0, 8'h05, 2'b00);
    give_byte(0, 8'hFB, 2'b00);
    give_byte(0, 8'h01, 2'b00);
    check_pkt(0);
    @(negedge clk);
    chk("w_int_low", send_int[0], 0);
    chk("w_int_once", int_cnt0 - base, 1);

    // Resync: first byte without bit3 is dropped
    base = int_cnt0;
    pkt_q.push_back(32'h08010203);
    give_byte(0, 8'h00, 2'b00);
    give_byte(0, 8'h08, 2'b00);
    give_byte(0, 8'h01, 2'b00);
    give_byte(0, 8'h02, 2'b00);
    give_byte(0, 8'h03, 2'b00);
    check_pkt(0);
    @(negedge clk);
    chk("resync_once", int_cnt0 - base, 1);

    // Receive error on the last byte drops the packet
    base = int_cnt0;
    give_byte(0, 8'h08, 2'b00);
    give_byte(0, 8'h0A, 2'b00);
    give_byte(0, 8'h0B, 2'b00);
    give_byte(0, 8'h0C, 2'b01);
    repeat (2) @(negedge clk);
    check_hold0(32'h08010203, base);

    // Inter-byte gap drops the packet; the stragglers lack bit3
    give_byte(0, 8'h08, 2'b00);
    give_byte(0, 8'h0D, 2'b00);
    repeat (60) @(negedge clk);
    give_byte(0, 8'h02, 2'b00);
    give_byte(0, 8'h03, 2'b00);
    repeat (2) @(negedge clk);
    check_hold0(32'h08010203, base);

    // Back-to-back packets: next first byte arrives in the publish cycle
    base = int_cnt0;
    pkt_q.push_back(32'h08112233);
    pkt_q.push_back(32'h0C445566);
    give_byte(0, 8'h08, 2'b00);
    give_byte(0, 8'h11, 2'b00);
    give_byte(0, 8'h22, 2'b00);
    give_byte(0, 8'h33, 2'b00);
    check_pkt(0);
    give_byte(0, 8'h0C, 2'b00);
    give_byte(0, 8'h44, 2'b00);
    give_byte(0, 8'h55, 2'b00);
    give_byte(0, 8'h66, 2'b00);
    check_pkt(0);
    @(negedge clk);
    chk("b2b_two", int_cnt0 - base, 2);

    // Asynchronous reset mid-packet
    give_byte(0, 8'h08, 2'b00);
    give_byte(0, 8'h01, 2'b00);
    #2 rst_n[0] = 1'b0;
    #1;
    chk("arst_status", m_status[0], 0);
    chk("arst_dz", m_dz[0], 0);
    chk("arst_done", init_done[0], 0);
    chk("arst_wheel", wheel_mode[0], 0);
    chk("arst_rden", read_enable[0], 0);
    @(negedge clk);

    // Wheel-capable host, plain device (ID 00): 3-byte packets
    rst_n[0] = 1'b1;
    push_wheel_cmds();
    repeat (11) device_cmd(0, 8'h00, 1'b0);
    chk("id0_done", init_done[0], 1);
    chk("id0_wheel", wheel_mode[0], 0);
    pkt_q.push_back(32'h09102000);
    give_byte(0, 8'h09, 2'b00);
    give_byte(0, 8'h10, 2'b00);
    give_byte(0, 8'h20, 2'b00);
    check_pkt(0);
    @(negedge clk);

    // Silent device: two attempts, then permanent failure
    rst_n[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b1;
    for (int a = 0; a < 2; a++) begin
      cmd_q.push_back(8'hFF);
      wait_send(0, ok);
      e8 = cmd_q.pop_front();
      if (ok) chk("retry_cmd", byte_to_send[0], e8);
      @(negedge clk);
    end
    for (int i = 0; i < 400 && !init_fail[0]; i++) @(negedge clk);
    chk("fail_flag", init_fail[0], 1);
    n = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (send_byte[0]) n++;
    end
    chk("fail_quiet", n, 0);
    chk("fail_rden", read_enable[0], 0);
    chk("fail_not_done", init_done[0], 0);
    chk("fail_sticky", init_fail[0], 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mouse_master_sm_gen.md
Name: mouse_master_sm_gen

Overview:
Parametrised successor to the PS/2 mouse master state machine. Sits between the PS/2 byte transmitter/receiver and the mouse register/interrupt logic. Runs a configurable init sequence (reset, optional IntelliMouse wheel detection, sample-rate set, enable streaming). It has bounded retries with timeouts, then decodes 3-byte or 4-byte stream packets with resynchronisation.

Parameters:
WHEEL_EN, 1, 1 = run wheel-detect sequence (F3 C8, F3 64, F3 50, F2); 0 = skip it, 3-byte mode only
SAMPLE_RATE, 8'd100, byte sent after final F3 command
INIT_TIMEOUT, 50_000_000, max CLK cycles waiting on any single init event (BYTE_SENT or response byte)
PACKET_TIMEOUT, 1_000_000, max CLK cycles between bytes of one stream packet
MAX_RETRIES, 3, init restarts allowed after a failure (total attempts = MAX_RETRIES+1)

Ports:
CLK  in  1  system clock
RESET_N  in  1  asynchronous active-low reset
SEND_BYTE  out  1  one-cycle request to transmitter
BYTE_TO_SEND  out  8  command byte, stable from SEND_BYTE until BYTE_SENT
BYTE_SENT  in  1  one-cycle transmit-complete pulse
READ_ENABLE  out  1  receiver enable
BYTE_READ  in  8  received byte, valid with BYTE_READY
BYTE_ERROR_CODE  in  2  receiver error (00 = ok), valid with BYTE_READY
BYTE_READY  in  1  one-cycle receive pulse
MOUSE_STATUS  out  8  packet byte 0
MOUSE_DX  out  8  packet byte 1
MOUSE_DY  out  8  packet byte 2
MOUSE_DZ  out  8  packet byte 3 in wheel mode, else 0
SEND_INTERRUPT  out  1  one-cycle pulse per accepted packet
WHEEL_MODE  out  1  1 = device ID 0x03 detected, 4-byte packets
INIT_DONE  out  1  high while streaming
INIT_FAIL  out  1  sticky high after retries are exhausted

Behaviour:
- Reset (RESET_N low, async): all outputs 0, retry counter 0, state = SEND_CMD with command index 0. Reset mid-operation aborts immediately; no partial packet is published.
- Command table, in order: FF; [F3, C8, F3, 64, F3, 50, F2 when WHEEL_EN]; F3, SAMPLE_RATE, F4.
- SEND_CMD: load BYTE_TO_SEND and pulse SEND_BYTE for 1 cycle. Go to WAIT_SENT.
- WAIT_SENT: READ_ENABLE=0. On BYTE_SENT go to WAIT_ACK. BYTE_READY is ignored in this state.
- WAIT_ACK: READ_ENABLE=1. A clean byte FA advances. Any other byte, a nonzero error code, or a timeout is a failure.
- After the FF ack: WAIT_AA expects AA, then WAIT_ID0 expects 00. Any mismatch is a failure.
- After the F2 ack: WAIT_ID. A clean byte 03 sets WHEEL_MODE=1; any other clean byte sets 0 and is not a failure. An error code or timeout is a failure.
- After the F4 ack: INIT_DONE=1, go to STREAM_B0.
- Timeout: counter clears on every state entry and counts while waiting. Reaching INIT_TIMEOUT is a failure.
- Failure handling: if retries < MAX_RETRIES, increment retries, clear WHEEL_MODE, restart at command index 0. Otherwise go to FAIL.
- FAIL: INIT_FAIL=1, READ_ENABLE=0, SEND_BYTE=0. Only RESET_N exits this state.
- STREAM_B0: accepts a clean byte only if bit3=1. Otherwise discard it and stay (resync).
- STREAM_B1, B2, (B3 when WHEEL_MODE): capture into shadow registers.
- Stream errors: a nonzero error code, or PACKET_TIMEOUT elapsing between bytes, drops the partial packet and returns to B0. Outputs stay unchanged. No stream timeout applies in B0.
- Packet completion: on the cycle after the final byte, copy shadows to MOUSE_* together. MOUSE_DZ=0 when WHEEL_MODE=0. Pulse SEND_INTERRUPT for exactly 1 cycle.
- Latency: last BYTE_READY to SEND_INTERRUPT is 1 cycle.
- A BYTE_READY arriving in the publish cycle is captured as the next B0.
- MOUSE_* hold their values between packets.

Test Plan:
- WHEEL_EN=0: release reset; ack FF with FA, AA, 00; ack F3, 64, F4 with FA -> byte sequence FF, F3, 64, F4 observed; INIT_DONE=1; WHEEL_MODE=0.
- WHEEL_EN=1 with ID reply 03, then stream 08 05 FB 01 -> MOUSE_STATUS=08, DX=05, DY=FB, DZ=01; SEND_INTERRUPT high for exactly 1 cycle.
- WHEEL_EN=1 with ID reply 00 -> WHEEL_MODE=0; stream 09 10 20 publishes a 3-byte packet with DZ=00.
- Reply FE to FF, then normal sequence -> retry taken; FF resent; INIT_DONE=1. With MAX_RETRIES=1, no replies and INIT_TIMEOUT=100 -> INIT_FAIL=1 after 2 attempts, SEND_BYTE stays 0.
- Stream 00 (bit3=0) then 08 01 02 -> first byte discarded; packet 08/01/02 published once.
- Stream 08 01, then BYTE_ERROR_CODE=01 on byte 3 (or PACKET_TIMEOUT gap) -> no interrupt, outputs unchanged. RESET_N low mid-packet -> all outputs 0 asynchronously.
